// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file slice.
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;
    localparam int unsigned NUM_WP        = 2;

    // Write-port index; ALU port has priority over the load port.
    typedef enum logic {
        WP_ALU  = 1'b0,
        WP_LOAD = 1'b1
    } wp_idx_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks reserved destination registers and their count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_rd,
    input  logic             clr0_en,
    input  logic [AW-1:0]    clr0_rd,
    input  logic             clr1_en,
    input  logic [AW-1:0]    clr1_rd,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] falls;
    logic             inc;
    logic [AW:0]      dec;
    logic [AW:0]      count_next;

    // Decode set/clear requests; a same-cycle reservation overrides a clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_en && (rsv_rd != AW'(REG_ZERO))) set_vec[rsv_rd] = 1'b1;
        if (clr0_en && (clr0_rd != AW'(REG_ZERO))) clr_vec[clr0_rd] = 1'b1;
        if (clr1_en && (clr1_rd != AW'(REG_ZERO))) clr_vec[clr1_rd] = 1'b1;
        busy_next = (busy & ~clr_vec) | set_vec;
        inc       = |(set_vec & ~busy);
        falls     = busy & clr_vec & ~set_vec;
        dec       = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            dec = dec + (AW+1)'(falls[r]);
        end
        count_next = busy_count + (AW+1)'(inc) - dec;
    end

    // Busy bits and their running population count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports, NREAD combinational read ports,
// optional write-to-read bypass, collision flag and reservation scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] read_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  wr0_en,
    input  logic [AW-1:0]         wr0_rd,
    input  logic [XLEN-1:0]       wr0_data,
    input  logic                  wr1_en,
    input  logic [AW-1:0]         wr1_rd,
    input  logic [XLEN-1:0]       wr1_data,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_rd,
    output logic                  wr_collision,
    output logic [AW:0]           busy_count
);

    logic [XLEN-1:0]  regs    [NREGS];
    logic             wp_act  [NUM_WP];
    logic [AW-1:0]    wp_rd   [NUM_WP];
    logic [XLEN-1:0]  wp_data [NUM_WP];
    logic [NREGS-1:0] busy;
    logic             collide;
    logic [AW-1:0]    rd_addr;
    logic [XLEN-1:0]  rd_val;
    logic             rd_bsy;

    // Gather write ports; a write to register 0 is never active.
    always_comb begin
        wp_rd[WP_ALU]    = wr0_rd;
        wp_rd[WP_LOAD]   = wr1_rd;
        wp_data[WP_ALU]  = wr0_data;
        wp_data[WP_LOAD] = wr1_data;
        wp_act[WP_ALU]   = wr0_en && (wr0_rd != AW'(REG_ZERO));
        wp_act[WP_LOAD]  = wr1_en && (wr1_rd != AW'(REG_ZERO));
        collide          = wp_act[WP_ALU] && wp_act[WP_LOAD] &&
                           (wp_rd[WP_ALU] == wp_rd[WP_LOAD]);
    end

    // Storage; the ALU write is applied last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            if (wp_act[WP_LOAD]) regs[wp_rd[WP_LOAD]] <= wp_data[WP_LOAD];
            if (wp_act[WP_ALU])  regs[wp_rd[WP_ALU]]  <= wp_data[WP_ALU];
        end
    end

    // One-cycle registered pulse for a dual write to the same register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_collision <= 1'b0;
        else       wr_collision <= collide;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rsv_en     (rsv_en),
        .rsv_rd     (rsv_rd),
        .clr0_en    (wr0_en),
        .clr0_rd    (wr0_rd),
        .clr1_en    (wr1_en),
        .clr1_rd    (wr1_rd),
        .busy       (busy),
        .busy_count (busy_count)
    );

    // Read ports with optional forwarding; ALU match checked last for priority.
    always_comb begin
        read_data = '0;
        rs_busy   = '0;
        rd_addr   = '0;
        rd_val    = '0;
        rd_bsy    = 1'b0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            rd_addr = rs[i*AW +: AW];
            rd_val  = regs[rd_addr];
            rd_bsy  = busy[rd_addr];
            if (BYPASS != 0) begin
                if (wp_act[WP_LOAD] && (wp_rd[WP_LOAD] == rd_addr)) begin
                    rd_val = wp_data[WP_LOAD];
                    rd_bsy = 1'b0;
                end
                if (wp_act[WP_ALU] && (wp_rd[WP_ALU] == rd_addr)) begin
                    rd_val = wp_data[WP_ALU];
                    rd_bsy = 1'b0;
                end
            end
            read_data[i*XLEN +: XLEN] = rd_val;
            rs_busy[i]                = rd_bsy;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: BYPASS=1 and BYPASS=0 instances share stimulus and are
// compared against an array-based reference model.
module tb_register_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic reset;
    logic [NREAD*AW-1:0]   rs;
    logic [NREAD*XLEN-1:0] rd_b, rd_n;
    logic [NREAD-1:0]      busy_b, busy_n;
    logic                  wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]         wr0_rd, wr1_rd, rsv_rd;
    logic [XLEN-1:0]       wr0_data, wr1_data;
    logic                  coll_b, coll_n;
    logic [AW:0]           cnt_b, cnt_n;

    int vectors = 0;
    int miscompares = 0;

    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];
    bit              m_coll;

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .rs(rs), .read_data(rd_b), .rs_busy(busy_b),
        .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .wr_collision(coll_b), .busy_count(cnt_b));

    register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .rs(rs), .read_data(rd_n), .rs_busy(busy_n),
        .wr0_en(wr0_en), .wr0_rd(wr0_rd), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_rd(wr1_rd), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_rd(rsv_rd), .wr_collision(coll_n), .busy_count(cnt_n));

    task automatic drive(input bit e0, input int r0, input int d0,
                         input bit e1, input int r1, input int d1,
                         input bit rv, input int rr, input int a0, input int a1);
        wr0_en = e0; wr0_rd = AW'(r0); wr0_data = XLEN'(d0);
        wr1_en = e1; wr1_rd = AW'(r1); wr1_data = XLEN'(d1);
        rsv_en = rv; rsv_rd = AW'(rr);
        rs = {AW'(a1), AW'(a0)};
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r] = '0;
            m_busy[r] = 0;
        end
        m_coll = 0;
    endtask

    // Advance one clock edge; the model applies the architectural rules first.
    task automatic tick();
        bit c;
        if (!reset) begin
            c = wr0_en && wr1_en && wr0_rd == wr1_rd && wr0_rd != 0;
            if (wr1_en && wr1_rd != 0) begin m_reg[wr1_rd] = wr1_data; m_busy[wr1_rd] = 0; end
            if (wr0_en && wr0_rd != 0) begin m_reg[wr0_rd] = wr0_data; m_busy[wr0_rd] = 0; end
            if (rsv_en && rsv_rd != 0) m_busy[rsv_rd] = 1;
            m_coll = c;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int r = 0; r < NREGS; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && wr0_en && wr0_rd == a) return wr0_data;
        if (byp && wr1_en && wr1_rd == a) return wr1_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && ((wr0_en && wr0_rd == a) || (wr1_en && wr1_rd == a))) return 0;
        return m_busy[a];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        drive(1, 1, 55, 1, 2, 66, 1, 1, 1, 2);
        repeat (2) @(posedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        #1;
        vectors++; if (cnt_b !== '0 || cnt_n !== '0) begin miscompares++; $display("FAIL reset_count got %0d/%0d exp 0", cnt_b, cnt_n); end
        vectors++; if (coll_b !== 1'b0 || coll_n !== 1'b0) begin miscompares++; $display("FAIL reset_collision got %b/%b exp 0", coll_b, coll_n); end
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++; if (rd_b !== '0 || rd_n !== '0) begin miscompares++; $display("FAIL reset_discard_write got %h/%h exp 0", rd_b, rd_n); end
        vectors++; if (busy_b !== '0 || busy_n !== '0) begin miscompares++; $display("FAIL reset_discard_rsv got %b/%b exp 0", busy_b, busy_n); end
    endtask

    task automatic test_write_read();
        drive(1, 1, 100, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        vectors++; if (rd_b[31:0] !== 32'd100 || rd_n[31:0] !== 32'd100) begin miscompares++; $display("FAIL write_read got %0d/%0d exp 100", rd_b[31:0], rd_n[31:0]); end
        vectors++; if (busy_b[0] !== 1'b0) begin miscompares++; $display("FAIL write_read_busy got %b exp 0", busy_b[0]); end
    endtask

    task automatic test_bypass();
        drive(1, 2, 200, 0, 0, 0, 0, 0, 0, 2);
        #1;
        vectors++; if (rd_b[63:32] !== 32'd200) begin miscompares++; $display("FAIL bypass_on got %0d exp 200", rd_b[63:32]); end
        vectors++; if (rd_n[63:32] !== 32'd0) begin miscompares++; $display("FAIL bypass_off_before got %0d exp 0", rd_n[63:32]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        #1;
        vectors++; if (rd_n[63:32] !== 32'd200) begin miscompares++; $display("FAIL bypass_off_after got %0d exp 200", rd_n[63:32]); end
    endtask

    task automatic test_collision();
        drive(1, 5, 11, 1, 5, 22, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        vectors++; if (coll_b !== 1'b1 || coll_n !== 1'b1) begin miscompares++; $display("FAIL collision_pulse got %b/%b exp 1", coll_b, coll_n); end
        vectors++; if (rd_b[31:0] !== 32'd11 || rd_n[31:0] !== 32'd11) begin miscompares++; $display("FAIL collision_data got %0d/%0d exp 11", rd_b[31:0], rd_n[31:0]); end
        tick();
        vectors++; if (coll_b !== 1'b0 || coll_n !== 1'b0) begin miscompares++; $display("FAIL collision_one_cycle got %b/%b exp 0", coll_b, coll_n); end
    endtask

    task automatic test_scoreboard();
        drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        vectors++; if (cnt_b !== 6'd1 || cnt_n !== 6'd1) begin miscompares++; $display("FAIL rsv_count got %0d/%0d exp 1", cnt_b, cnt_n); end
        vectors++; if (busy_b[0] !== 1'b1 || busy_n[0] !== 1'b1) begin miscompares++; $display("FAIL rsv_busy got %b/%b exp 1", busy_b[0], busy_n[0]); end
        drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
        tick();
        vectors++; if (cnt_b !== 6'd1) begin miscompares++; $display("FAIL rsv_again_count got %0d exp 1", cnt_b); end
        drive(0, 0, 0, 1, 3, 7, 0, 0, 3, 0);
        #1;
        vectors++; if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b1) begin miscompares++; $display("FAIL write_busy_bypass got %b/%b exp 0/1", busy_b[0], busy_n[0]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        #1;
        vectors++; if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin miscompares++; $display("FAIL release_count got %0d/%0d exp 0", cnt_b, cnt_n); end
        vectors++; if (rd_b[31:0] !== 32'd7 || rd_n[31:0] !== 32'd7) begin miscompares++; $display("FAIL release_data got %0d/%0d exp 7", rd_b[31:0], rd_n[31:0]); end
    endtask

    task automatic test_rsv_write();
        drive(1, 4, 9, 0, 0, 0, 1, 4, 4, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        #1;
        vectors++; if (rd_b[31:0] !== 32'd9) begin miscompares++; $display("FAIL rsv_write_data got %0d exp 9", rd_b[31:0]); end
        vectors++; if (busy_b[0] !== 1'b1 || cnt_b !== 6'd1) begin miscompares++; $display("FAIL rsv_write_busy got %b cnt %0d exp 1 cnt 1", busy_b[0], cnt_b); end
        drive(1, 0, 300, 0, 0, 0, 1, 0, 0, 0);
        #1;
        vectors++; if (rd_b[31:0] !== 32'd0 || busy_b[0] !== 1'b0) begin miscompares++; $display("FAIL zero_bypass got %0d busy %b exp 0", rd_b[31:0], busy_b[0]); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        vectors++; if (rd_n[31:0] !== 32'd0 || cnt_n !== 6'd1) begin miscompares++; $display("FAIL zero_reg got %0d cnt %0d exp 0 cnt 1", rd_n[31:0], cnt_n); end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 7);
        vectors++; if (cnt_b !== 6'd3) begin miscompares++; $display("FAIL pre_reset_count got %0d exp 3", cnt_b); end
        @(negedge clk);
        #1 reset = 1'b1;
        model_clear();
        #1;
        vectors++; if (rd_b !== '0 || rd_n !== '0) begin miscompares++; $display("FAIL async_reset_data got %h/%h exp 0", rd_b, rd_n); end
        vectors++; if (busy_b !== '0 || cnt_b !== '0 || cnt_n !== '0 || coll_b !== 1'b0) begin miscompares++; $display("FAIL async_reset_state got busy %b cnt %0d/%0d coll %b exp 0", busy_b, cnt_b, cnt_n, coll_b); end
        #2 reset = 1'b0;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 6, 7);
        #1;
        vectors++; if (rd_b !== '0 || busy_b !== '0 || cnt_b !== '0 || cnt_n !== '0) begin miscompares++; $display("FAIL post_reset got data %h busy %b cnt %0d exp 0", rd_b, busy_b, cnt_b); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            #1;
            for (int p = 0; p < NREAD; p++) begin
                a = rs[p*AW +: AW];
                vectors++; if (rd_b[p*XLEN +: XLEN] !== exp_rd(a, 1)) begin miscompares++; $display("FAIL rand_read_b port %0d addr %0d got %h exp %h", p, a, rd_b[p*XLEN +: XLEN], exp_rd(a, 1)); end
                vectors++; if (rd_n[p*XLEN +: XLEN] !== exp_rd(a, 0)) begin miscompares++; $display("FAIL rand_read_n port %0d addr %0d got %h exp %h", p, a, rd_n[p*XLEN +: XLEN], exp_rd(a, 0)); end
                vectors++; if (busy_b[p] !== exp_busy(a, 1) || busy_n[p] !== exp_busy(a, 0)) begin miscompares++; $display("FAIL rand_busy port %0d addr %0d got %b/%b exp %b/%b", p, a, busy_b[p], busy_n[p], exp_busy(a, 1), exp_busy(a, 0)); end
            end
            tick();
            vectors++; if (cnt_b !== 6'(popcnt()) || cnt_n !== 6'(popcnt())) begin miscompares++; $display("FAIL rand_count got %0d/%0d exp %0d", cnt_b, cnt_n, popcnt()); end
            vectors++; if (coll_b !== m_coll || coll_n !== m_coll) begin miscompares++; $display("FAIL rand_collision got %b/%b exp %b", coll_b, coll_n, m_coll); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_rsv_write();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL take parameter XLEN, default 32: the data width in bits.
REQ-002 The block SHALL take parameter NREGS, default 32: the register count, a power of two and at least 2; AW = $clog2(NREGS).
REQ-003 The block SHALL take parameter NREAD, default 2: the read port count, from 1 to 4.
REQ-004 The block SHALL take parameter BYPASS, default 1: 1 enables write-to-read forwarding in the same cycle.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-007 Port rs, input, NREAD*AW bits, SHALL carry the flattened read addresses; port i uses bits [i*AW +: AW].
REQ-008 Port read_data, output, NREAD*XLEN bits, SHALL carry the flattened read data.
REQ-009 Port rs_busy, output, NREAD bits, SHALL flag that the register addressed by read port i is reserved.
REQ-010 Ports wr0_en (1 bit), wr0_rd (AW bits) and wr0_data (XLEN bits), all inputs, SHALL form write port 0, the ALU port.
REQ-011 Ports wr1_en (1 bit), wr1_rd (AW bits) and wr1_data (XLEN bits), all inputs, SHALL form write port 1, the load port.
REQ-012 Ports rsv_en (1 bit) and rsv_rd (AW bits), both inputs, SHALL request a scoreboard reservation of a destination register.
REQ-013 Port wr_collision, output, 1 bit, SHALL be a registered one-cycle pulse for a same-cycle same-address dual write.
REQ-014 Port busy_count, output, AW+1 bits, SHALL be the registered number of reserved registers.

Function
REQ-015 Reads SHALL be combinational; read_data[i] = reg[rs[i]].
REQ-016 Register 0 SHALL always read 0, never be written, and never be busy; writes and reservations targeting it are ignored.
REQ-017 A write port SHALL commit wrN_data to reg[wrN_rd] at the clock edge when wrN_en=1 and wrN_rd!=0.
REQ-018 When both ports write the same nonzero rd in one cycle, port 0 data SHALL be stored, and wr_collision SHALL be 1 for exactly the next cycle.
REQ-019 With BYPASS=1, a read port whose rs matches an enabled nonzero write rd SHALL return that write data in the same cycle, with port 0 priority when both match.
REQ-020 With BYPASS=0, the new value SHALL become visible the cycle after the write edge.
REQ-021 The busy bit of register r SHALL be set at the edge on which rsv_en=1 and rsv_rd=r with r!=0.
REQ-022 The busy bit of register r SHALL be cleared at the edge on which either write port writes r.
REQ-023 When a reservation and a write target the same register in one cycle, the reservation SHALL win and the busy bit ends set.
REQ-024 rs_busy[i] SHALL be busy[rs[i]] combinationally, cleared for a same-cycle matching write only when BYPASS=1.
REQ-025 busy_count SHALL equal the population count of the busy bits after each edge: a counter incremented per set and decremented per clear, never exceeding NREGS-1.
REQ-026 Reserving an already-busy register SHALL leave the busy bit set and busy_count unchanged.
REQ-027 A write to a non-busy register SHALL leave busy_count unchanged.

Reset
REQ-028 While reset=1, all registers SHALL be 0, all busy bits 0, busy_count 0 and wr_collision 0, asynchronously and regardless of clk.
REQ-029 Writes and reservations presented during reset SHALL be discarded, and normal operation SHALL resume at the first edge after reset deasserts.
REQ-030 A reset asserted mid-operation SHALL clear pending reservations, so no stale busy bit survives reset.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the default XLEN and NREGS constants, the REG_ZERO address constant, and the write-port index enumeration (WP_ALU=0, WP_LOAD=1).
REQ-032 Sub-module regfile_scoreboard SHALL own the busy bits, the set/clear priority logic and busy_count; the storage, bypass and collision logic SHALL stay in the top level.

Verification
REQ-033 Reset then write rd=1, 100 on port 0, read rs[0]=1 the next cycle -> read_data[0]=100 and rs_busy[0]=0.
REQ-034 With BYPASS=1, wr0 rd=2, 200 and rs[1]=2 in the same cycle -> read_data[1]=200 before the edge; with BYPASS=0 -> the old value 0 before the edge and 200 after it.
REQ-035 Same cycle wr0 rd=5, 11 and wr1 rd=5, 22 -> reg5=11 and wr_collision=1 for one cycle only.
REQ-036 Reserve rd=3 -> busy_count=1 and rs_busy=1; reserve rd=3 again -> busy_count=1; wr1 rd=3, 7 -> busy_count=0 and read returns 7.
REQ-037 Same cycle rsv rd=4 and wr0 rd=4, 9 -> reg4=9, busy4=1 and busy_count=1; write 300 and reserve rd=0 -> reg0 reads 0 and busy_count is unchanged.
REQ-038 Reserve rd=6 and rd=7, then assert reset for half a clock between edges -> all outputs 0 immediately; after release, reg6 reads 0 and busy_count=0.
